// File: rtl/seg_disp_pkg.sv
// Shared constants for the multiplexed seven-segment display driver.
package seg_disp_pkg;

  localparam int unsigned MAX_DIGITS = 8;

  // Segment patterns, abcdefg with bit6 = a; 0 = segment lit.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex7seg_dec
  import seg_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] a_to_g
);

  // Full 16-entry lookup.
  always_comb begin
    a_to_g = SEG_BLANK;
    unique case (nibble)
      4'h0: a_to_g = SEG_0;
      4'h1: a_to_g = SEG_1;
      4'h2: a_to_g = SEG_2;
      4'h3: a_to_g = SEG_3;
      4'h4: a_to_g = SEG_4;
      4'h5: a_to_g = SEG_5;
      4'h6: a_to_g = SEG_6;
      4'h7: a_to_g = SEG_7;
      4'h8: a_to_g = SEG_8;
      4'h9: a_to_g = SEG_9;
      4'hA: a_to_g = SEG_A;
      4'hB: a_to_g = SEG_B;
      4'hC: a_to_g = SEG_C;
      4'hD: a_to_g = SEG_D;
      4'hE: a_to_g = SEG_E;
      4'hF: a_to_g = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg_mux_disp.sv
// Time-multiplexed N-digit hex seven-segment driver with double-buffered load,
// per-digit enable, decimal points and leading-zero blanking. Outputs active-low.
module seg_mux_disp
  import seg_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_CYC   = 16
) (
  input  logic                    clk_,
  input  logic                    rst_,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  output logic [6:0]              a_to_g,
  output logic [NUM_DIGITS-1:0]   AN_,
  output logic                    dp_,
  output logic                    frame_done
);

  localparam int unsigned IdxW = $clog2(NUM_DIGITS);
  localparam int unsigned PreW = $clog2(REFRESH_DIV);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_DIGITS - 1);
  localparam logic [PreW-1:0] PreLast  = PreW'(REFRESH_DIV - 1);
  localparam logic [PreW-1:0] BlankEnd = PreW'(BLANK_CYC);

  logic [PreW-1:0]         pre_q;
  logic [IdxW-1:0]         idx_q;
  logic                    wrap;

  logic [4*NUM_DIGITS-1:0] pend_val_q, act_val_q;
  logic [NUM_DIGITS-1:0]   pend_dp_q, act_dp_q;
  logic [NUM_DIGITS-1:0]   pend_en_q, act_en_q;
  logic                    pend_flag_q;

  logic [3:0]              act_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   lz_hide;
  logic                    zero_above;
  logic                    show;
  logic [6:0]              dec_seg;

  logic [NUM_DIGITS-1:0]   an_d, an_q;
  logic [6:0]              seg_d, seg_q;
  logic                    dp_d, dp_q;

  // Frame boundary: last cycle of the last digit slot.
  always_comb begin
    wrap = (pre_q == PreLast) && (idx_q == IdxLast);
  end

  // Slot prescaler and digit index.
  always_ff @(posedge clk_ or negedge rst_) begin
    if (!rst_) begin
      pre_q <= '0;
      idx_q <= '0;
    end else if (pre_q == PreLast) begin
      pre_q <= '0;
      idx_q <= (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  // Double buffer: pending captures loads, active only changes at a frame wrap.
  always_ff @(posedge clk_ or negedge rst_) begin
    if (!rst_) begin
      pend_val_q  <= '0;
      pend_dp_q   <= '0;
      pend_en_q   <= '0;
      pend_flag_q <= 1'b0;
      act_val_q   <= '0;
      act_dp_q    <= '0;
      act_en_q    <= '0;
    end else if (load && wrap) begin
      // Coincident load bypasses pending so it shows in the very next frame.
      pend_val_q  <= value;
      pend_dp_q   <= dp_in;
      pend_en_q   <= digit_en;
      pend_flag_q <= 1'b0;
      act_val_q   <= value;
      act_dp_q    <= dp_in;
      act_en_q    <= digit_en;
    end else if (load) begin
      pend_val_q  <= value;
      pend_dp_q   <= dp_in;
      pend_en_q   <= digit_en;
      pend_flag_q <= 1'b1;
    end else if (wrap && pend_flag_q) begin
      act_val_q   <= pend_val_q;
      act_dp_q    <= pend_dp_q;
      act_en_q    <= pend_en_q;
      pend_flag_q <= 1'b0;
    end
  end

  // Leading-zero detection, scanning from the most significant digit down.
  always_comb begin
    zero_above = 1'b1;
    lz_hide    = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      act_nib[i] = act_val_q[4*i +: 4];
      lz_hide[i] = lz_blank && (i != 0) && (act_nib[i] == 4'h0) && zero_above;
      if (act_en_q[i] && (act_nib[i] != 4'h0)) begin
        zero_above = 1'b0;
      end
    end
    show = act_en_q[idx_q] && !lz_hide[idx_q];
  end

  hex7seg_dec u_dec (
    .nibble (act_nib[idx_q]),
    .a_to_g (dec_seg)
  );

  // Next output values: dark during the anti-ghost window or when hidden.
  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (!(pre_q < BlankEnd) && show) begin
      an_d[idx_q] = 1'b0;
      seg_d       = dec_seg;
      dp_d        = ~act_dp_q[idx_q];
    end
  end

  // Registered pin drivers; reset forces everything dark immediately.
  always_ff @(posedge clk_ or negedge rst_) begin
    if (!rst_) begin
      an_q  <= '1;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign AN_        = an_q;
  assign a_to_g     = seg_q;
  assign dp_        = dp_q;
  assign frame_done = wrap;

endmodule
